// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage (master) and div_unit (slave).
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; upper half feeds HI, lower half feeds LO.
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the result
// (quo=0, rem=dividend) is produced straight from FREE without iterating.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, result forced to 0 next
// ON     | one shift/subtract per cycle, cnt = iteration index
// END    | ready_o high, result held until start_i drops
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [2*DATA_W:0]     work, work_n, work_step;
    logic [DATA_W-1:0]     divisor, divisor_n;
    logic                  neg_quo, neg_quo_n;
    logic                  neg_rem, neg_rem_n;
    logic [2*DATA_W-1:0]   result, result_n;
    logic                  ready, ready_n;

    logic                  accept;
    logic                  a_neg, b_neg, b_zero, early;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     q_raw, r_raw, q_fix, r_fix;
    logic                  last_iter;

    assign accept    = (state == S_FREE) && bus.start_i && !bus.annul_i;
    assign a_neg     = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign b_neg     = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign a_mag     = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign b_mag     = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    assign b_zero    = (bus.opdata2_i == '0);
    assign last_iter = (cnt == CW'(DATA_W - 1));

`ifdef DIV_EARLY_OUT_EN
    assign early = !b_zero && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // work holds {partial remainder, remaining dividend bits, quotient bits},
    // pre-shifted by one so the top DATA_W+1 bits are the current trial minuend.
    always_comb begin
        diff = work[2*DATA_W:DATA_W] - {1'b0, divisor};
        if (diff[DATA_W]) begin
            work_step = {work[2*DATA_W-1:0], 1'b0};
        end else begin
            work_step = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
        end
        q_raw = work_step[DATA_W-1:0];
        r_raw = work_step[2*DATA_W:DATA_W+1];
        q_fix = neg_quo ? (~q_raw + 1'b1) : q_raw;
        r_fix = neg_rem ? (~r_raw + 1'b1) : r_raw;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            S_FREE: begin
                if (accept) begin
                    if (b_zero)     state_n = S_BYZERO;
                    else if (early) state_n = S_END;
                    else            state_n = S_ON;
                end
            end
            S_BYZERO: state_n = S_END;
            S_ON: begin
                if (bus.annul_i)    state_n = S_FREE;
                else if (last_iter) state_n = S_END;
            end
            S_END: begin
                if (bus.annul_i || !bus.start_i) state_n = S_FREE;
            end
            default: state_n = S_FREE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        neg_quo_n = neg_quo;
        neg_rem_n = neg_rem;
        result_n  = result;
        ready_n   = ready;
        case (state)
            S_FREE: begin
                if (accept) begin
                    cnt_n     = '0;
                    work_n    = {{DATA_W{1'b0}}, a_mag, 1'b0};
                    divisor_n = b_mag;
                    neg_quo_n = a_neg ^ b_neg;
                    neg_rem_n = a_neg;
                    if (early && !b_zero) begin
                        result_n = {bus.opdata1_i, {DATA_W{1'b0}}};
                        ready_n  = 1'b1;
                    end
                end
            end
            S_BYZERO: begin
                result_n = '0;
                ready_n  = 1'b1;
            end
            S_ON: begin
                if (!bus.annul_i) begin
                    work_n = work_step;
                    cnt_n  = cnt + CW'(1);
                    if (last_iter) begin
                        result_n = {r_fix, q_fix};
                        ready_n  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (bus.annul_i || !bus.start_i) ready_n = 1'b0;
            end
            default: ready_n = 1'b0;
        endcase
    end

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FREE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            divisor <= divisor_n;
            neg_quo <= neg_quo_n;
            neg_rem <= neg_rem_n;
            result  <= result_n;
            ready   <= ready_n;
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
endmodule
